dram_line_master: RTL and testbench
===================================

# dram_line_master

Initiator-side sequencer for the single-port DRAM model. It accepts whole-line read and write requests from a cache or dataflow node over a valid/ready interface. It breaks each request into `BEATS` consecutive word accesses on the DRAM port (`wr`/`addr`/`din`/`dout`, one-cycle registered read latency). It returns the assembled line, or a write acknowledgment, on a valid/ready response interface.

## Interface
- `DATA`, 32, word width; matches the DRAM `DATA`.
- `ADDR`, 28, word address width; matches the DRAM `ADDR`.
- `BEATS`, 4, words per line; power of two, at least 2. `LINE = DATA*BEATS`. `OFF = log2(BEATS)`.
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_wr`  in  1  1 = line write, 0 = line read.
- `req_addr`  in  ADDR  line word address; the low `OFF` bits are ignored (forced to 0).
- `req_wdata`  in  LINE  write line; beat i is `[i*DATA +: DATA]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_wr`  out  1  echo of `req_wr` for this response.
- `resp_rdata`  out  LINE  read line, same beat packing; unchanged by writes.
- `mem_wr`  out  1  to DRAM `wr`.
- `mem_addr`  out  ADDR  to DRAM `addr`.
- `mem_din`  out  DATA  to DRAM `din`.
- `mem_dout`  in  DATA  from DRAM `dout`; valid the cycle after the address edge.

## Operation
- **States:** IDLE, WRITE, READ, RESP.
- **Output registering:** all outputs are registered except `req_ready`, which equals `(state==IDLE)`.
- **Accept:** a request is accepted at the edge where `req_valid && req_ready` is high. At that edge:
  - latch `base = {req_addr[ADDR-1:OFF], OFF'b0}`, `req_wr` and `req_wdata`;
  - clear the beat counter `cnt` (`OFF` bits wide);
  - drive `mem_addr <= base`.
- **WRITE:**
  - `mem_wr=1` and `mem_din=wdata[cnt]` while in WRITE.
  - Each edge increments `cnt` and `mem_addr`.
  - After beat `BEATS-1` is presented, the next edge deasserts `mem_wr` and enters RESP.
- **READ:**
  - `mem_wr=0`; `mem_addr` steps `base..base+BEATS-1`, one address per cycle.
  - A one-cycle delayed valid/index pipe captures `mem_dout` into line buffer slot i two edges after address i is driven.
  - Capture of the last slot enters RESP.
- **RESP:**
  - `resp_valid=1`; `resp_rdata`/`resp_wr` are held stable.
  - On `resp_ready`, return to IDLE. `req_ready` rises the following cycle; requests never overlap.
- **Address arithmetic:** `mem_addr = base + cnt`. Alignment guarantees no carry out of the line, so the address never wraps past `2**ADDR-1`.
- **Idle hold:** `mem_addr` and `mem_din` hold their last values in IDLE/RESP; `mem_wr` is 0 outside WRITE.
- **Reset (asynchronous):**
  - State goes to IDLE; `mem_wr=0`, `mem_addr=0`, `mem_din=0`, `resp_valid=0`, `resp_wr=0`, `resp_rdata=0`, `cnt=0`.
  - Reset mid-WRITE: beats already committed stay in the DRAM and no response is produced.
  - Reset mid-READ: the partial line is discarded.

## Timing
Edge 0 is the accept edge.
- **Write:**
  - `mem_wr` is high from edge 0 to edge `BEATS`.
  - Beat i is committed by the DRAM at edge i+1.
  - `resp_valid` rises at edge `BEATS`.
  - Accept-to-response: `BEATS` cycles.
- **Read:**
  - Address i is driven after edge i and sampled by the DRAM at edge i+1.
  - `mem_dout` is captured at edge i+2.
  - `resp_valid` rises at edge `BEATS+1`.
  - Accept-to-response: `BEATS+1` cycles.
- **Handshake:** the response completes at the first edge with `resp_valid && resp_ready`. IDLE is reached at that edge; the earliest next accept is the edge after.
- **Throughput:** minimum request period is `BEATS+2` cycles (write) or `BEATS+3` cycles (read) with `resp_ready` held high.
- **Simultaneous events:** `req_valid` during WRITE, READ or RESP is ignored (`req_ready=0`), and the request is held by the source.

## Test plan
1. **Reset:** hold `rst_n=0` for 3 cycles with random inputs -> `req_ready=1`, `resp_valid=0`, `mem_wr=0`, `mem_addr=0`, `resp_rdata=0`.
2. **Write line:** write at `0x10` with beats {1,2,3,4} -> `mem_wr` high for 4 cycles; `mem_addr` 0x10,0x11,0x12,0x13 with `mem_din` 1,2,3,4; `resp_valid` at edge 4 with `resp_wr=1`.
3. **Read back:** read at `0x10` -> `mem_wr` stays 0; `resp_valid` at edge 5; `resp_rdata=0x00000004_00000003_00000002_00000001`; `resp_wr=0`.
4. **Unaligned request:** read at `req_addr=0x13` -> `mem_addr` sequence 0x10..0x13 and the same line as scenario 3. Also read the top line `0xFFFFFFC` -> addresses end at `0xFFFFFFF` without wrap.
5. **Backpressure:** keep `resp_ready=0` for 10 cycles during RESP while `req_valid=1` -> `resp_valid`/`resp_rdata` stable, `req_ready=0`, `mem_wr=0`. Release -> IDLE, and the next accept occurs one cycle later.
6. **Reset mid-write:** write {A,B,C,D} at `0x20` and drop `rst_n` after edge 2 -> `mem_wr` falls immediately, no `resp_valid`. A subsequent read of `0x20` returns A,B plus the prior contents at 0x22/0x23.

Source files
------------

// File: rtl/dram_line_master.sv
// Whole-line read/write sequencer in front of a single-port DRAM with one-cycle read latency.
// Each request becomes BEATS consecutive word accesses; the result comes back on a valid/ready response.
module dram_line_master #(
  parameter int DATA  = 32,
  parameter int ADDR  = 28,
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR-1:0]       req_addr,
  input  logic [DATA*BEATS-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_wr,
  output logic [DATA*BEATS-1:0] resp_rdata,
  output logic                  mem_wr,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA-1:0]       mem_din,
  input  logic [DATA-1:0]       mem_dout
);
  localparam int OFF = $clog2(BEATS);
  localparam logic [OFF-1:0] LAST = OFF'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [OFF-1:0]             cnt_reg;
  logic [BEATS-1:0][DATA-1:0] wdata_reg;
  logic [BEATS-1:0][DATA-1:0] line_reg;
  logic [BEATS-1:0][DATA-1:0] req_line;
  logic                       rd_valid_reg;
  logic [OFF-1:0]             rd_idx_reg;
  logic                       mem_wr_reg;
  logic [ADDR-1:0]            mem_addr_reg;
  logic [DATA-1:0]            mem_din_reg;
  logic                       resp_valid_reg;
  logic                       resp_wr_reg;
  logic                       last_capture;
  logic                       unused_addr_bits;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_pack
      assign req_line[gi]                 = req_wdata[gi*DATA +: DATA];
      assign resp_rdata[gi*DATA +: DATA]  = line_reg[gi];
    end
  endgenerate

  // Line offset bits of the request address are dropped on purpose.
  assign unused_addr_bits = ^req_addr[OFF-1:0];

  assign req_ready    = (state_reg == IDLE);
  assign last_capture = rd_valid_reg && (rd_idx_reg == LAST);
  assign mem_wr       = mem_wr_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_din      = mem_din_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_wr      = resp_wr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_wr ? WRITE : READ;
      WRITE:   if (cnt_reg == LAST) state_next = RESP;
      READ:    if (last_capture) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      wdata_reg      <= '0;
      line_reg       <= '0;
      rd_valid_reg   <= 1'b0;
      rd_idx_reg     <= '0;
      mem_wr_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      resp_valid_reg <= 1'b0;
      resp_wr_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            mem_addr_reg <= {req_addr[ADDR-1:OFF], {OFF{1'b0}}};
            cnt_reg      <= '0;
            wdata_reg    <= req_line;
            mem_wr_reg   <= req_wr;
            if (req_wr) mem_din_reg <= req_line[0];
          end
        end
        WRITE: begin
          if (cnt_reg == LAST) begin
            mem_wr_reg     <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_wr_reg    <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg + OFF'(1);
            mem_addr_reg <= mem_addr_reg + ADDR'(1);
            mem_din_reg  <= wdata_reg[cnt_reg + OFF'(1)];
          end
        end
        READ: begin
          // The address presented now is sampled at this edge; its data appears one edge later.
          rd_valid_reg <= !last_capture;
          rd_idx_reg   <= cnt_reg;
          if (cnt_reg != LAST) begin
            cnt_reg      <= cnt_reg + OFF'(1);
            mem_addr_reg <= mem_addr_reg + ADDR'(1);
          end
          if (rd_valid_reg) line_reg[rd_idx_reg] <= mem_dout;
          if (last_capture) begin
            resp_valid_reg <= 1'b1;
            resp_wr_reg    <= 1'b0;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_line_master.sv
// Randomized self-checking bench for dram_line_master with a word-level DRAM and a line-level reference memory.
module tb_dram_line_master;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wr = 1'b0;
  logic [27:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_wr;
  logic [127:0] resp_rdata;
  logic         mem_wr;
  logic [27:0]  mem_addr;
  logic [31:0]  mem_din;
  logic [31:0]  mem_dout;

  int tests = 0;
  int fails = 0;

  logic [31:0]  dram    [logic [27:0]];
  logic [31:0]  ref_mem [logic [27:0]];
  logic         tr_wr   [$];
  logic [27:0]  tr_addr [$];
  logic [31:0]  tr_din  [$];
  logic [127:0] last_rd = '0;

  always #5 clk = ~clk;

  dram_line_master #(.DATA(32), .ADDR(28), .BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_rdata(resp_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Single-port DRAM: registered read of the old word, write on the same edge.
  always @(posedge clk) begin
    mem_dout <= dram.exists(mem_addr) ? dram[mem_addr] : 32'h0;
    if (mem_wr) dram[mem_addr] = mem_din;
  end

  function automatic logic [27:0] line_base(input logic [27:0] a);
    return {a[27:2], 2'b00};
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] a);
    logic [127:0] l;
    logic [27:0]  w;
    l = '0;
    for (int b = 0; b < 4; b++) begin
      w = line_base(a) + 28'(b);
      l[b*32 +: 32] = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    end
    return l;
  endfunction

  task automatic ref_write(input logic [27:0] a, input logic [127:0] l, input int nbeats);
    for (int b = 0; b < nbeats; b++) ref_mem[line_base(a) + 28'(b)] = l[b*32 +: 32];
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request, records the DRAM-port trace after each edge, then accepts the response.
  task automatic do_req(input logic wr, input logic [27:0] a, input logic [127:0] wd,
                        output logic [127:0] rd, output logic rwr, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    tr_wr.delete(); tr_addr.delete(); tr_din.delete();
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0; req_addr = 28'($urandom); req_wdata = rand_line(); req_wr = 1'($urandom);
      end
      tr_wr.push_back(mem_wr); tr_addr.push_back(mem_addr); tr_din.push_back(mem_din);
      if (resp_valid) begin lat = k; break; end
    end
    rd = resp_rdata; rwr = resp_wr;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_wr = 1'($urandom); req_addr = 28'($urandom);
      req_wdata = rand_line(); resp_ready = 1'($urandom);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 28'h0 ||
        resp_rdata !== 128'h0 || mem_din !== 32'h0 || resp_wr !== 1'b0) begin
      fails++;
      $display("FAIL reset got rdy=%b rv=%b wr=%b addr=%h din=%h rwr=%b rdata=%h want 1 0 0 0 0 0 0",
               req_ready, resp_valid, mem_wr, mem_addr, mem_din, resp_wr, resp_rdata);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    rst_n = 1'b1;
    $display("[TB] reset done");
  endtask

  task automatic test_write_line();
    logic [127:0] wd, rd;
    logic rwr;
    int lat;
    wd = 128'h00000004_00000003_00000002_00000001;
    do_req(1'b1, 28'h10, wd, rd, rwr, lat);
    $display("[TB] write addr=%h lat=%0d", 28'h10, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL write_lat got %0d want 4", lat); end
    tests++;
    if (rwr !== 1'b1) begin fails++; $display("FAIL write_resp_wr got %b want 1", rwr); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (tr_wr[k] !== 1'b1 || tr_addr[k] !== 28'h10 + 28'(k) || tr_din[k] !== 32'(k + 1)) begin
        fails++;
        $display("FAIL write_beat%0d got wr=%b addr=%h din=%h want 1 %h %h",
                 k, tr_wr[k], tr_addr[k], tr_din[k], 28'h10 + 28'(k), 32'(k + 1));
      end
    end
    tests++;
    if (tr_wr[4] !== 1'b0) begin fails++; $display("FAIL write_end_wr got %b want 0", tr_wr[4]); end
    tests++;
    if (rd !== last_rd) begin fails++; $display("FAIL write_rdata got %h want %h", rd, last_rd); end
    ref_write(28'h10, wd, 4);
  endtask

  task automatic test_read_back();
    logic [127:0] rd;
    logic rwr;
    int lat;
    do_req(1'b0, 28'h10, rand_line(), rd, rwr, lat);
    $display("[TB] read addr=%h lat=%0d data=%h", 28'h10, lat, rd);
    tests++;
    if (lat !== 5) begin fails++; $display("FAIL read_lat got %0d want 5", lat); end
    tests++;
    if (rwr !== 1'b0) begin fails++; $display("FAIL read_resp_wr got %b want 0", rwr); end
    tests++;
    if (rd !== 128'h00000004_00000003_00000002_00000001) begin
      fails++; $display("FAIL read_data got %h want 00000004000000030000000200000001", rd);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (tr_wr[k] !== 1'b0 || (k < 4 && tr_addr[k] !== 28'h10 + 28'(k))) begin
        fails++;
        $display("FAIL read_cycle%0d got wr=%b addr=%h want 0 %h", k, tr_wr[k], tr_addr[k], 28'h10 + 28'(k));
      end
    end
    last_rd = rd;
  endtask

  task automatic test_unaligned();
    logic [127:0] rd, wd;
    logic rwr;
    int lat;
    do_req(1'b0, 28'h13, rand_line(), rd, rwr, lat);
    $display("[TB] read addr=%h lat=%0d data=%h", 28'h13, lat, rd);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (tr_addr[k] !== 28'h10 + 28'(k)) begin
        fails++; $display("FAIL unaligned_addr%0d got %h want %h", k, tr_addr[k], 28'h10 + 28'(k));
      end
    end
    tests++;
    if (rd !== ref_line(28'h10)) begin fails++; $display("FAIL unaligned_data got %h want %h", rd, ref_line(28'h10)); end
    last_rd = rd;
    wd = rand_line();
    do_req(1'b1, 28'hFFFFFFC, wd, rd, rwr, lat);
    $display("[TB] write addr=%h lat=%0d", 28'hFFFFFFC, lat);
    ref_write(28'hFFFFFFC, wd, 4);
    do_req(1'b0, 28'hFFFFFFD, rand_line(), rd, rwr, lat);
    $display("[TB] read addr=%h lat=%0d data=%h", 28'hFFFFFFD, lat, rd);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (tr_addr[k] !== (k < 4 ? 28'hFFFFFFC + 28'(k) : 28'hFFFFFFF)) begin
        fails++; $display("FAIL top_addr%0d got %h", k, tr_addr[k]);
      end
    end
    tests++;
    if (rd !== ref_line(28'hFFFFFFC)) begin fails++; $display("FAIL top_data got %h want %h", rd, ref_line(28'hFFFFFFC)); end
    last_rd = rd;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_line, wd;
    int n;
    exp_line = ref_line(28'h10);
    wd = rand_line();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 28'h10; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_wr = 1'b1; req_addr = 28'h40; req_wdata = wd;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (resp_valid !== 1'b1) begin fails++; $display("FAIL bp_resp got %b want 1", resp_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_line || req_ready !== 1'b0 || mem_wr !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got rv=%b rdata=%h rdy=%b wr=%b want 1 %h 0 0",
                 i, resp_valid, resp_rdata, req_ready, mem_wr, exp_line);
      end
    end
    $display("[TB] backpressure held 10 cycles data=%h", resp_rdata);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release got rdy=%b rv=%b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (req_ready !== 1'b0 || mem_wr !== 1'b1 || mem_addr !== 28'h40 || mem_din !== wd[31:0]) begin
      fails++;
      $display("FAIL bp_next_accept got rdy=%b wr=%b addr=%h din=%h want 0 1 0000040 %h",
               req_ready, mem_wr, mem_addr, mem_din, wd[31:0]);
    end
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (resp_valid !== 1'b1 || resp_wr !== 1'b1 || resp_rdata !== exp_line) begin
      fails++; $display("FAIL bp_next_resp got rv=%b rwr=%b rdata=%h want 1 1 %h", resp_valid, resp_wr, resp_rdata, exp_line);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    ref_write(28'h40, wd, 4);
    last_rd = exp_line;
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] prior, nw, rd;
    logic rwr;
    int lat;
    prior = rand_line();
    nw = rand_line();
    do_req(1'b1, 28'h20, prior, rd, rwr, lat);
    ref_write(28'h20, prior, 4);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 28'h20; req_wdata = nw;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_wr !== 1'b0 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL midwr_reset got wr=%b rv=%b want 0 0", mem_wr, resp_valid);
    end
    ref_write(28'h20, nw, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b0 || mem_wr !== 1'b0) begin
        fails++; $display("FAIL midwr_quiet%0d got rv=%b wr=%b want 0 0", i, resp_valid, mem_wr);
      end
    end
    last_rd = '0;
    do_req(1'b0, 28'h20, rand_line(), rd, rwr, lat);
    $display("[TB] read after mid-write reset data=%h", rd);
    tests++;
    if (rd !== ref_line(28'h20)) begin fails++; $display("FAIL midwr_data got %h want %h", rd, ref_line(28'h20)); end
    last_rd = rd;
  endtask

  task automatic test_random();
    logic [127:0] wd, rd;
    logic [27:0] a;
    logic wr, rwr;
    int lat;
    for (int it = 0; it < 16; it++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 28'h100 + 28'($urandom_range(0, 31));
      wd = rand_line();
      do_req(wr, a, wd, rd, rwr, lat);
      $display("[TB] rand%0d %s addr=%h lat=%0d rdata=%h", it, wr ? "wr" : "rd", a, lat, rd);
      tests++;
      if (lat !== (wr ? 4 : 5) || rwr !== wr) begin
        fails++; $display("FAIL rand%0d_lat got lat=%0d rwr=%b want %0d %b", it, lat, rwr, wr ? 4 : 5, wr);
      end
      tests++;
      if (tr_addr[0] !== line_base(a) || tr_addr[3] !== line_base(a) + 28'd3 || tr_wr[0] !== wr) begin
        fails++; $display("FAIL rand%0d_addr got %h..%h wr=%b want %h", it, tr_addr[0], tr_addr[3], tr_wr[0], line_base(a));
      end
      if (wr) begin
        for (int k = 0; k < 4; k++) begin
          tests++;
          if (tr_din[k] !== wd[k*32 +: 32]) begin
            fails++; $display("FAIL rand%0d_din%0d got %h want %h", it, k, tr_din[k], wd[k*32 +: 32]);
          end
        end
        tests++;
        if (rd !== last_rd) begin fails++; $display("FAIL rand%0d_wr_rdata got %h want %h", it, rd, last_rd); end
        ref_write(a, wd, 4);
      end else begin
        tests++;
        if (rd !== ref_line(a)) begin fails++; $display("FAIL rand%0d_data got %h want %h", it, rd, ref_line(a)); end
        last_rd = rd;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_line();
    test_read_back();
    test_unaligned();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
